// File: rtl/crc8_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module   : crc8_serial_rx
//  Purpose  : Serial frame receiver with CRC8 check (poly 0x2F, init 0xFF,
//             no final XOR). Deserialises DATA_W payload bits followed by
//             8 CRC bits, MSB first, and reports the frame with a one-cycle
//             strobe plus held pass/fail and CRC values.
//  Revision : 1.0 - initial release
// ============================================================================
module crc8_serial_rx #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 7,
  parameter int TMO_CYC = 0,
  parameter int TMO_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic              i_data,
  input  logic              i_sof,
  output logic [DATA_W-1:0] o_data,
  output logic              o_frm_vld,
  output logic              o_crc_ok,
  output logic              o_crc_err,
  output logic [7:0]        o_calc_crc,
  output logic [7:0]        o_rx_crc,
  output logic              o_abort,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(7);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);
  localparam logic             TMO_EN    = (TMO_CYC > 0);

  state_t            state;
  logic [7:0]        crc;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] payload_next;
  logic [6:0]        rx_shift;
  logic [7:0]        rx_crc_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  // One LFSR step: shift left, fold in 0x2F when (c7 ^ d) is set.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    crc8_step = {c[6], c[5], c[4] ^ fb, c[3], c[2] ^ fb, c[1] ^ fb, c[0] ^ fb, fb};
  endfunction

  // Payload shift register input; a 1-bit payload simply takes the new bit.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign payload_next = i_data;
    end else begin : g_shift_wide
      assign payload_next = {payload[DATA_W-2:0], i_data};
    end
  endgenerate

  // Received CRC field including the bit arriving this cycle.
  assign rx_crc_next = {rx_shift, i_data};

  assign o_busy = (state != IDLE);

  // Frame FSM: deserialise, run the CRC, publish results or abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      crc        <= 8'hFF;
      payload    <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      o_data     <= '0;
      o_frm_vld  <= 1'b0;
      o_crc_ok   <= 1'b0;
      o_crc_err  <= 1'b0;
      o_calc_crc <= 8'hFF;
      o_rx_crc   <= 8'h00;
      o_abort    <= 1'b0;
    end else begin
      o_frm_vld <= 1'b0;
      o_abort   <= 1'b0;
      if (i_vld) begin
        tmo_cnt <= '0;
        if (i_sof) begin
          // A start bit always opens a new frame; mid-frame it discards the old one.
          o_abort <= (state != IDLE);
          crc     <= crc8_step(8'hFF, i_data);
          payload <= payload_next;
          if (DATA_W == 1) begin
            state   <= CRC;
            bit_cnt <= '0;
          end else begin
            state   <= DATA;
            bit_cnt <= CNT_ONE;
          end
        end else begin
          case (state)
            DATA: begin
              crc     <= crc8_step(crc, i_data);
              payload <= payload_next;
              if (bit_cnt == DATA_LAST) begin
                state   <= CRC;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
            CRC: begin
              rx_shift <= rx_crc_next[6:0];
              if (bit_cnt == CRC_LAST) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                o_frm_vld  <= 1'b1;
                o_data     <= payload;
                o_rx_crc   <= rx_crc_next;
                o_calc_crc <= crc;
                o_crc_ok   <= (crc == rx_crc_next);
                o_crc_err  <= (crc != rx_crc_next);
              end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
              end
            end
            default: begin
              // Bits without a start marker are ignored while idle.
            end
          endcase
        end
      end else if (TMO_EN && (state != IDLE)) begin
        // Count idle cycles inside a frame; give up after TMO_CYC of them.
        if (tmo_cnt == TMO_LAST) begin
          o_abort <= 1'b1;
          state   <= IDLE;
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc8_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc8_serial_rx
//  Purpose  : Directed self-checking bench for crc8_serial_rx. Instance A has
//             a 16-bit payload with a 4-cycle timeout, instance B an 8-bit
//             payload with the timeout disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc8_serial_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_vld = 1'b0, a_din = 1'b0, a_sof = 1'b0;
  logic [15:0] a_data;
  logic        a_frm, a_ok, a_err, a_abort, a_busy;
  logic [7:0]  a_calc, a_rx;

  logic        b_vld = 1'b0, b_din = 1'b0, b_sof = 1'b0;
  logic [7:0]  b_data;
  logic        b_frm, b_ok, b_err, b_abort, b_busy;
  logic [7:0]  b_calc, b_rx;

  int checks = 0;
  int failures = 0;
  int frm_cnt_a = 0, abort_cnt_a = 0, frm_cnt_b = 0, both_cnt = 0;
  logic first_abort = 1'b0;

  crc8_serial_rx #(.DATA_W(16), .CNT_W(7), .TMO_CYC(4), .TMO_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_vld(a_vld), .i_data(a_din), .i_sof(a_sof),
    .o_data(a_data), .o_frm_vld(a_frm), .o_crc_ok(a_ok), .o_crc_err(a_err),
    .o_calc_crc(a_calc), .o_rx_crc(a_rx), .o_abort(a_abort), .o_busy(a_busy)
  );

  crc8_serial_rx #(.DATA_W(8), .CNT_W(5), .TMO_CYC(0), .TMO_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_vld(b_vld), .i_data(b_din), .i_sof(b_sof),
    .o_data(b_data), .o_frm_vld(b_frm), .o_crc_ok(b_ok), .o_crc_err(b_err),
    .o_calc_crc(b_calc), .o_rx_crc(b_rx), .o_abort(b_abort), .o_busy(b_busy)
  );

  // Strobe bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_frm) frm_cnt_a <= frm_cnt_a + 1;
    if (a_abort) abort_cnt_a <= abort_cnt_a + 1;
    if (b_frm) frm_cnt_b <= frm_cnt_b + 1;
    if ((a_frm && a_abort) || (b_frm && b_abort)) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: bitwise shift register with polynomial 0x2F, seed 0xFF.
  function automatic logic [7:0] crc_model(input logic [15:0] d, input int n);
    logic [7:0] c;
    logic fb;
    c = 8'hFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h2F;
    end
    return c;
  endfunction

  task automatic drive_a(input logic v, input logic s, input logic d);
    a_vld = v; a_sof = s; a_din = d;
    @(posedge clk); #1;
    a_vld = 1'b0; a_sof = 1'b0; a_din = 1'b0;
  endtask

  task automatic drive_b(input logic v, input logic s, input logic d);
    b_vld = v; b_sof = s; b_din = d;
    @(posedge clk); #1;
    b_vld = 1'b0; b_sof = 1'b0; b_din = 1'b0;
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) drive_a(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_b(input int n);
    for (int k = 0; k < n; k++) drive_b(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame_a(input logic [15:0] d, input logic [7:0] c, input int gap_max);
    logic bitv;
    int g;
    for (int i = 0; i < 24; i++) begin
      if (i > 0 && gap_max > 0) begin
        g = int'($urandom_range(gap_max, 0));
        idle_a(g);
      end
      bitv = (i < 16) ? d[15-i] : c[23-i];
      drive_a(1'b1, (i == 0), bitv);
      if (i == 0) first_abort = a_abort;
    end
  endtask

  task automatic send_frame_b(input logic [7:0] d, input logic [7:0] c, input int gap_max);
    logic bitv;
    int g;
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && gap_max > 0) begin
        g = int'($urandom_range(gap_max, 0));
        idle_b(g);
      end
      bitv = (i < 8) ? d[7-i] : c[15-i];
      drive_b(1'b1, (i == 0), bitv);
    end
  endtask

  logic [15:0] pat;
  logic [7:0]  crc_exp;
  logic [7:0]  crc_tail;
  int fa, ab;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check_eq("rst_data", a_data, 0);
    check_eq("rst_frm", a_frm, 0);
    check_eq("rst_ok", a_ok, 0);
    check_eq("rst_err", a_err, 0);
    check_eq("rst_calc", a_calc, 8'hFF);
    check_eq("rst_rx", a_rx, 8'h00);
    check_eq("rst_abort", a_abort, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_b_calc", b_calc, 8'hFF);
    rst = 1'b0;
    idle_a(2);

    // T1: all-zero payload, correct CRC
    send_frame_a(16'h0000, 8'hB8, 0);
    check_eq("t1_frm", a_frm, 1);
    check_eq("t1_data", a_data, 16'h0000);
    check_eq("t1_ok", a_ok, 1);
    check_eq("t1_err", a_err, 0);
    check_eq("t1_calc", a_calc, 8'hB8);
    check_eq("t1_rx", a_rx, 8'hB8);
    check_eq("t1_busy", a_busy, 0);
    idle_a(1);
    check_eq("t1_frm_1cyc", a_frm, 0);
    check_eq("t1_ok_held", a_ok, 1);

    // T2: 8-bit payload, wrong CRC
    send_frame_b(8'h00, 8'h43, 0);
    check_eq("t2_frm", b_frm, 1);
    check_eq("t2_err", b_err, 1);
    check_eq("t2_ok", b_ok, 0);
    check_eq("t2_calc", b_calc, 8'h42);
    check_eq("t2_rx", b_rx, 8'h43);
    idle_b(1);
    crc_exp = crc_model(16'h00A5, 8);
    send_frame_b(8'hA5, crc_exp, 0);
    check_eq("t2b_ok", b_ok, 1);
    check_eq("t2b_data", b_data, 8'hA5);
    idle_b(1);
    // Long gaps with the timeout disabled must not abort
    crc_exp = crc_model(16'h003C, 8);
    send_frame_b(8'h3C, crc_exp, 20);
    check_eq("t2c_ok", b_ok, 1);
    check_eq("t2c_calc", b_calc, crc_exp);
    idle_b(1);
    check_eq("t2c_frames", frm_cnt_b, 3);

    // T3: gapped frame, then a back-to-back frame starting on the strobe
    fa = frm_cnt_a;
    send_frame_a(16'h0000, 8'hB8, 3);
    check_eq("t3_frm1", a_frm, 1);
    check_eq("t3_ok1", a_ok, 1);
    crc_exp = crc_model(16'h1234, 16);
    send_frame_a(16'h1234, crc_exp, 3);
    check_eq("t3_frm2", a_frm, 1);
    check_eq("t3_ok2", a_ok, 1);
    check_eq("t3_data2", a_data, 16'h1234);
    idle_a(1);
    check_eq("t3_strobes", frm_cnt_a - fa, 2);

    // T4: restart mid-frame
    fa = frm_cnt_a;
    ab = abort_cnt_a;
    pat = 16'hABCD;
    for (int i = 0; i < 10; i++) drive_a(1'b1, (i == 0), pat[15-i]);
    check_eq("t4_busy", a_busy, 1);
    check_eq("t4_data_hold", a_data, 16'h1234);
    crc_exp = crc_model(16'h5A5A, 16);
    send_frame_a(16'h5A5A, crc_exp, 0);
    check_eq("t4_abort", first_abort, 1);
    check_eq("t4_frm", a_frm, 1);
    check_eq("t4_data", a_data, 16'h5A5A);
    check_eq("t4_ok", a_ok, 1);
    idle_a(1);
    check_eq("t4_abort_cnt", abort_cnt_a - ab, 1);
    check_eq("t4_frm_cnt", frm_cnt_a - fa, 1);

    // T5: timeout after 4 idle cycles mid-frame
    pat = 16'hF0F0;
    for (int i = 0; i < 5; i++) drive_a(1'b1, (i == 0), pat[15-i]);
    idle_a(3);
    check_eq("t5_no_abort_yet", a_abort, 0);
    check_eq("t5_busy_yet", a_busy, 1);
    idle_a(1);
    check_eq("t5_abort", a_abort, 1);
    check_eq("t5_busy", a_busy, 0);
    idle_a(1);
    check_eq("t5_abort_1cyc", a_abort, 0);
    fa = frm_cnt_a;
    for (int i = 0; i < 24; i++) drive_a(1'b1, 1'b0, i[0]);
    idle_a(1);
    check_eq("t5_ignored_busy", a_busy, 0);
    check_eq("t5_ignored_frm", frm_cnt_a - fa, 0);
    check_eq("t5_data_hold", a_data, 16'h5A5A);

    // T6: reset during the CRC field
    fa = frm_cnt_a;
    crc_tail = 8'hB8;
    for (int i = 0; i < 16; i++) drive_a(1'b1, (i == 0), 1'b0);
    for (int i = 0; i < 3; i++) drive_a(1'b1, 1'b0, crc_tail[7-i]);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_data", a_data, 0);
    check_eq("t6_ok", a_ok, 0);
    check_eq("t6_err", a_err, 0);
    check_eq("t6_calc", a_calc, 8'hFF);
    check_eq("t6_rx", a_rx, 8'h00);
    check_eq("t6_busy", a_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i < 8; i++) drive_a(1'b1, 1'b0, crc_tail[7-i]);
    idle_a(1);
    check_eq("t6_no_strobe", frm_cnt_a - fa, 0);
    check_eq("t6_idle", a_busy, 0);
    send_frame_a(16'h0000, 8'hB8, 2);
    check_eq("t6_frm", a_frm, 1);
    check_eq("t6_pass", a_ok, 1);
    check_eq("t6_calc2", a_calc, 8'hB8);
    idle_a(2);

    check_eq("strobe_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
